execute_stage: RTL and testbench
================================

# execute_stage

Execute stage of the pipelined RV32 core: consumes the Decode→Execute register outputs, applies forwarding, runs the ALU, resolves branches and jumps, and drives the Execute→Memory pipeline register. Also contains a 32-cycle iterative shift-add multiplier that raises a busy/stall signal to the hazard unit while it runs. Sits between the Decode/Execute register and the Memory stage.

## Interface
- WIDTH, 32, datapath width (RTL and tests are defined for 32 only)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, JALRctrlE  in  1 each  control from the Decode/Execute register
- ResultSrcE  in  2  result-select control
- ALUControlE  in  3  ALU operation select
- RD1E, RD2E, PCE, ImmExtE, PCPlus4E  in  WIDTH each  operands and PC values
- RdE  in  5  destination register
- ForwardAE, ForwardBE  in  2 each  forwarding select from the hazard unit: 00 = RD*E, 01 = ResultW, 10 = ALUResultM, 11 = RD*E
- ResultW  in  WIDTH  writeback result for forwarding
- PCSrcE  out  1  redirect fetch (combinational)
- PCTargetE  out  WIDTH  redirect target (combinational)
- BusyE  out  1  multiplier occupying E; hazard unit stalls F/D/E (combinational)
- RegWriteM, MemWriteM  out  1 each  registered controls
- ResultSrcM  out  2  registered control
- ALUResultM, WriteDataM, PCPlus4M  out  WIDTH each  registered data
- RdM  out  5  registered destination

## Operation
- SrcAE = forwarding mux(ForwardAE). WriteDataE = forwarding mux(ForwardBE). SrcBE = ALUSrcE ? ImmExtE : WriteDataE.
- ALUControlE encoding: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt (signed, result 0/1), 110 sll (shift amount SrcBE[4:0]), 111 mul (low 32 bits of product, modulo 2^32).
- ZeroE = (ALUResultE == 0). Branches are bne: PCSrcE = JumpE | (BranchE & ~ZeroE). PCSrcE is forced to 0 for op 111.
- PCTargetE = JALRctrlE ? (ALUResultE & ~1) : (PCE + ImmExtE).
- The multiply request is MulReq = RegWriteE & (ALUControlE == 111). Bubbles carry RegWriteE=0 and never start the multiplier.
- Multiplier FSM:
  - IDLE: when MulReq is set, capture the multiplicand (SrcAE) and multiplier (SrcBE), clear the accumulator and the 5-bit counter, then go to MUL.
  - MUL: if multiplier[0] is set, acc += multiplicand. Then shift the multiplicand left by 1, shift the multiplier right by 1, and increment the counter. When counter == 31, go to DONE.
  - DONE: ALUResultE = acc. Return to IDLE.
- BusyE = (IDLE & MulReq) | MUL. It is 0 in DONE.
- E/M register: on each clock edge with BusyE=1, load a bubble (RegWriteM=0, MemWriteM=0, ResultSrcM=00, RdM=0, data=0). Otherwise, load the current Execute values. This register has no stall or flush input.

## Timing
- Reset (asynchronous, any state): all M outputs are 0, the FSM goes to IDLE, and the counter, accumulator and operand registers are 0. A multiply in progress is aborted with no result written.
- Non-mul ops take 1 cycle: M outputs reflect the Execute inputs on the next rising edge.
- PCSrcE, PCTargetE, and BusyE are combinational in the same cycle.
- Mul latency is 34 cycles in E: 1 IDLE capture cycle, 32 MUL cycles, 1 DONE cycle. BusyE is high for exactly 33 cycles. ALUResultM holds the product after the DONE-cycle edge.
- Forwarded operands are sampled only in the IDLE capture cycle. Changes to ResultW or ALUResultM after that cycle have no effect.
- Back-to-back muls: the second mul is presented after DONE and starts from IDLE on the next cycle. No dead cycle is added beyond this.
- ForwardAE/ForwardBE and RD*E changes during MUL are ignored.

## Test plan
- Forwarding add: RD1E=5, ForwardAE=10 with ALUResultM=100, ALUSrcE=1, ImmExtE=3, op 000 → ALUResultM=103 on the next edge.
- bne taken: BranchE=1, SrcA=4, SrcB=9, op 001, PCE=0x40, ImmExtE=0xFFFFFFF8 → PCSrcE=1 and PCTargetE=0x38 in the same cycle. With SrcA=SrcB=9 → PCSrcE=0.
- jalr: JumpE=1, JALRctrlE=1, RD1E=0x101, ImmExtE=4, PCPlus4E=0x24 → PCTargetE=0x104, PCSrcE=1, and PCPlus4M=0x24 after the edge.
- mul 7×6: BusyE is high for 33 cycles, M outputs are bubbles during that time, and ALUResultM=42 with RegWriteM=1 after the 34th edge.
- mul 0xFFFFFFFF×2 → ALUResultM=0xFFFFFFFE. A second mul 3×0 presented immediately after → 0 after 34 further edges.
- Assert rst during the 10th MUL cycle → BusyE=0, all M outputs 0, and FSM in IDLE immediately. After release, a following add completes in 1 cycle.

Source files
------------

// File: rtl/execute_stage_if.sv
// execute_stage_if
//   Bundles the Execute-stage signals of the RV32 pipeline:
//   - Decode/Execute register outputs (controls, operands, PC values, RdE)
//   - forwarding selects from the hazard unit and the writeback result
//   - redirect (PCSrcE/PCTargetE) and stall request (BusyE)
//   - Execute/Memory register outputs (*M)
//   master: the surrounding pipeline (drives E inputs, observes outputs)
//   slave : the execute stage itself
interface execute_stage_if #(
  parameter int WIDTH = 32
);
  logic             RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, JALRctrlE;
  logic [1:0]       ResultSrcE;
  logic [2:0]       ALUControlE;
  logic [WIDTH-1:0] RD1E, RD2E, PCE, ImmExtE, PCPlus4E;
  logic [4:0]       RdE;
  logic [1:0]       ForwardAE, ForwardBE;
  logic [WIDTH-1:0] ResultW;

  logic             PCSrcE;
  logic [WIDTH-1:0] PCTargetE;
  logic             BusyE;

  logic             RegWriteM, MemWriteM;
  logic [1:0]       ResultSrcM;
  logic [WIDTH-1:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]       RdM;

  modport master (
    output RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, JALRctrlE,
           ResultSrcE, ALUControlE, RD1E, RD2E, PCE, ImmExtE, PCPlus4E,
           RdE, ForwardAE, ForwardBE, ResultW,
    input  PCSrcE, PCTargetE, BusyE,
           RegWriteM, MemWriteM, ResultSrcM, ALUResultM, WriteDataM,
           PCPlus4M, RdM
  );

  modport slave (
    input  RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, JALRctrlE,
           ResultSrcE, ALUControlE, RD1E, RD2E, PCE, ImmExtE, PCPlus4E,
           RdE, ForwardAE, ForwardBE, ResultW,
    output PCSrcE, PCTargetE, BusyE,
           RegWriteM, MemWriteM, ResultSrcM, ALUResultM, WriteDataM,
           PCPlus4M, RdM
  );
endinterface

// File: rtl/execute_stage.sv
// execute_stage
//   RV32 Execute stage: operand forwarding, ALU, bne/jal/jalr resolution and
//   the Execute->Memory pipeline register. Op 111 (mul) runs on a 32-step
//   shift-add multiplier; BusyE asks the hazard unit to stall F/D/E while it
//   works, and the E/M register receives bubbles until the product is ready.
//   Ports: clk, rst (async, active-high), ex (execute_stage_if.slave).
module execute_stage #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst,
  execute_stage_if.slave  ex
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t           state_p0;
  logic [WIDTH-1:0] mcand_p0, mplier_p0, acc_p0;
  logic [4:0]       cnt_p0;

  logic [WIDTH-1:0] src_a, write_data, src_b, alu_result;
  logic             mul_op, mul_req, zero, busy;

  logic             regwrite_p1, memwrite_p1;
  logic [1:0]       resultsrc_p1;
  logic [WIDTH-1:0] alu_result_p1, write_data_p1, pcplus4_p1;
  logic [4:0]       rd_p1;

  function automatic logic [WIDTH-1:0] alu(input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b,
                                           input logic [2:0]       op);
    logic signed [WIDTH-1:0] sa, sb;
    sa = a;
    sb = b;
    case (op)
      3'b000:  alu = a + b;
      3'b001:  alu = a - b;
      3'b010:  alu = a & b;
      3'b011:  alu = a | b;
      3'b100:  alu = a ^ b;
      3'b101:  alu = (sa < sb) ? WIDTH'(1) : '0;
      3'b110:  alu = a << b[4:0];
      default: alu = '0;
    endcase
  endfunction

  // ---- stage p0: forwarding, ALU, branch resolution ----
  always_comb begin
    case (ex.ForwardAE)
      2'b01:   src_a = ex.ResultW;
      2'b10:   src_a = ex.ALUResultM;
      default: src_a = ex.RD1E;
    endcase
    case (ex.ForwardBE)
      2'b01:   write_data = ex.ResultW;
      2'b10:   write_data = ex.ALUResultM;
      default: write_data = ex.RD2E;
    endcase
    src_b   = ex.ALUSrcE ? ex.ImmExtE : write_data;
    mul_op  = (ex.ALUControlE == 3'b111);
    mul_req = ex.RegWriteE & mul_op;
    // The accumulator is only meaningful in DONE, which is the only cycle a
    // mul result can leave E (all earlier cycles load bubbles).
    alu_result = mul_op ? acc_p0 : alu(src_a, src_b, ex.ALUControlE);
    zero       = (alu_result == '0);
    // A reset in flight must drop the stall immediately, even though the
    // mul instruction may still be sitting on the inputs.
    busy = ~rst & (((state_p0 == S_IDLE) & mul_req) | (state_p0 == S_MUL));
  end

  assign ex.PCSrcE    = ~mul_op & (ex.JumpE | (ex.BranchE & ~zero));
  assign ex.PCTargetE = ex.JALRctrlE ? {alu_result[WIDTH-1:1], 1'b0}
                                     : (ex.PCE + ex.ImmExtE);
  assign ex.BusyE     = busy;

  // Iterative shift-add multiplier; operands are captured once in IDLE so
  // later forwarding/register changes cannot disturb the product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p0  <= S_IDLE;
      mcand_p0  <= '0;
      mplier_p0 <= '0;
      acc_p0    <= '0;
      cnt_p0    <= '0;
    end else begin
      case (state_p0)
        S_IDLE: begin
          if (mul_req) begin
            mcand_p0  <= src_a;
            mplier_p0 <= src_b;
            acc_p0    <= '0;
            cnt_p0    <= '0;
            state_p0  <= S_MUL;
          end
        end
        S_MUL: begin
          if (mplier_p0[0]) acc_p0 <= acc_p0 + mcand_p0;
          mcand_p0  <= mcand_p0 << 1;
          mplier_p0 <= mplier_p0 >> 1;
          cnt_p0    <= cnt_p0 + 5'd1;
          if (cnt_p0 == 5'd31) state_p0 <= S_DONE;
        end
        S_DONE:  state_p0 <= S_IDLE;
        default: state_p0 <= S_IDLE;
      endcase
    end
  end

  // ---- stage p1: Execute/Memory register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regwrite_p1   <= 1'b0;
      memwrite_p1   <= 1'b0;
      resultsrc_p1  <= '0;
      rd_p1         <= '0;
      alu_result_p1 <= '0;
      write_data_p1 <= '0;
      pcplus4_p1    <= '0;
    end else if (busy) begin
      regwrite_p1   <= 1'b0;
      memwrite_p1   <= 1'b0;
      resultsrc_p1  <= '0;
      rd_p1         <= '0;
      alu_result_p1 <= '0;
      write_data_p1 <= '0;
      pcplus4_p1    <= '0;
    end else begin
      regwrite_p1   <= ex.RegWriteE;
      memwrite_p1   <= ex.MemWriteE;
      resultsrc_p1  <= ex.ResultSrcE;
      rd_p1         <= ex.RdE;
      alu_result_p1 <= alu_result;
      write_data_p1 <= write_data;
      pcplus4_p1    <= ex.PCPlus4E;
    end
  end

  assign ex.RegWriteM  = regwrite_p1;
  assign ex.MemWriteM  = memwrite_p1;
  assign ex.ResultSrcM = resultsrc_p1;
  assign ex.RdM        = rd_p1;
  assign ex.ALUResultM = alu_result_p1;
  assign ex.WriteDataM = write_data_p1;
  assign ex.PCPlus4M   = pcplus4_p1;

endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage
//   Table vectors for the documented ALU/branch/jump cases, randomized
//   non-mul traffic checked against a plain-arithmetic reference model, and
//   hand-written sequences for multiply latency, back-to-back muls and
//   reset during a multiply.
module tb_execute_stage;
  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  execute_stage_if #(.WIDTH(32)) ex_if ();
  execute_stage #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .ex(ex_if));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6: return a << b[4:0];
      default: return a * b;
    endcase
  endfunction

  function automatic logic [31:0] ref_fwd(input logic [1:0] sel, input logic [31:0] rd,
                                          input logic [31:0] resw, input logic [31:0] alum);
    return (sel == 2'b01) ? resw : (sel == 2'b10) ? alum : rd;
  endfunction

  task automatic idle_inputs();
    ex_if.RegWriteE = 0; ex_if.MemWriteE = 0; ex_if.JumpE = 0; ex_if.BranchE = 0;
    ex_if.ALUSrcE = 0; ex_if.JALRctrlE = 0; ex_if.ResultSrcE = 0; ex_if.ALUControlE = 0;
    ex_if.RD1E = 0; ex_if.RD2E = 0; ex_if.PCE = 0; ex_if.ImmExtE = 0; ex_if.PCPlus4E = 0;
    ex_if.RdE = 0; ex_if.ForwardAE = 0; ex_if.ForwardBE = 0; ex_if.ResultW = 0;
  endtask

  task automatic chk_m_zero(input string name);
    chk({name, "_RegWriteM"}, {31'd0, ex_if.RegWriteM}, 0);
    chk({name, "_MemWriteM"}, {31'd0, ex_if.MemWriteM}, 0);
    chk({name, "_ResultSrcM"}, {30'd0, ex_if.ResultSrcM}, 0);
    chk({name, "_RdM"}, {27'd0, ex_if.RdM}, 0);
    chk({name, "_ALUResultM"}, ex_if.ALUResultM, 0);
    chk({name, "_WriteDataM"}, ex_if.WriteDataM, 0);
    chk({name, "_PCPlus4M"}, ex_if.PCPlus4M, 0);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic        alusrc, branch, jump, jalr;
    logic [1:0]  fa, fb;
    logic [31:0] rd1, rd2, imm, resw, pce, pcp4;
    logic [31:0] exp_alu;
    logic        exp_pcsrc;
    logic [31:0] exp_tgt;
  } vec_t;

  // Multiply a*b through the RD registers; scrambles SrcA sources while busy.
  task automatic do_mul(input string name, input logic [31:0] a, input logic [31:0] b);
    int busy_cnt;
    int bubble_bad;
    busy_cnt = 0;
    bubble_bad = 0;
    @(negedge clk);
    idle_inputs();
    ex_if.RegWriteE = 1; ex_if.ALUControlE = 3'b111; ex_if.RdE = 5'd5;
    ex_if.RD1E = a; ex_if.RD2E = b; ex_if.PCPlus4E = 32'h80;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!ex_if.BusyE) break;
      busy_cnt++;
      @(posedge clk); #1;
      if (ex_if.RegWriteM || ex_if.MemWriteM || ex_if.RdM != 0 || ex_if.ALUResultM != 0 ||
          ex_if.WriteDataM != 0 || ex_if.PCPlus4M != 0 || ex_if.ResultSrcM != 0)
        bubble_bad++;
      ex_if.RD1E = $urandom;
      ex_if.ResultW = $urandom;
      ex_if.ForwardAE = 2'($urandom_range(0, 3));
      @(negedge clk);
    end
    chk({name, "_busy_cycles"}, busy_cnt, 33);
    chk({name, "_bubbles"}, bubble_bad, 0);
    chk({name, "_pcsrc_done"}, {31'd0, ex_if.PCSrcE}, 0);
    @(posedge clk); #1;
    chk({name, "_product"}, ex_if.ALUResultM, ref_alu(a, b, 3'd7));
    chk({name, "_RegWriteM"}, {31'd0, ex_if.RegWriteM}, 1);
    chk({name, "_RdM"}, {27'd0, ex_if.RdM}, 5);
    chk({name, "_PCPlus4M"}, ex_if.PCPlus4M, 32'h80);
  endtask

  initial begin
    vec_t vt[10];
    logic [31:0] prev_alu;
    logic [31:0] a, b, wd, res;
    logic        pcsrc;

    vt[0] = '{3'd0,0,0,0,0,2'd0,2'd0,32'd60,32'd40,32'd0,32'd0,32'd0,32'h4,32'd100,0,32'd0};
    vt[1] = '{3'd0,1,0,0,0,2'd2,2'd0,32'd5,32'd0,32'd3,32'd0,32'd0,32'h8,32'd103,0,32'd3};
    vt[2] = '{3'd1,0,1,0,0,2'd0,2'd0,32'd4,32'd9,32'hFFFFFFF8,32'd0,32'h40,32'h44,32'hFFFFFFFB,1,32'h38};
    vt[3] = '{3'd1,0,1,0,0,2'd0,2'd0,32'd9,32'd9,32'hFFFFFFF8,32'd0,32'h40,32'h44,32'd0,0,32'h38};
    vt[4] = '{3'd0,1,0,1,1,2'd0,2'd0,32'h101,32'd0,32'd4,32'd0,32'h20,32'h24,32'h105,1,32'h104};
    vt[5] = '{3'd5,0,0,0,0,2'd0,2'd0,32'hFFFFFFFF,32'd1,32'd0,32'd0,32'd0,32'h0,32'd1,0,32'd0};
    vt[6] = '{3'd6,0,0,0,0,2'd0,2'd0,32'd3,32'h24,32'd0,32'd0,32'd0,32'h0,32'h30,0,32'd0};
    vt[7] = '{3'd4,0,0,0,0,2'd1,2'd3,32'd0,32'hFF00FF00,32'd0,32'hF0F0F0F0,32'd0,32'h0,32'h0FF00FF0,0,32'd0};
    vt[8] = '{3'd2,0,0,0,0,2'd0,2'd2,32'hFFFF0000,32'd0,32'd0,32'd0,32'd0,32'h0,32'h0FF00000,0,32'd0};
    vt[9] = '{3'd3,0,0,0,0,2'd0,2'd0,32'h12,32'h21,32'd0,32'd0,32'd0,32'h0,32'h33,0,32'd0};

    idle_inputs();
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    chk_m_zero("reset");
    chk("reset_busy", {31'd0, ex_if.BusyE}, 0);
    @(negedge clk);
    rst = 0;

    // Table vectors
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      idle_inputs();
      ex_if.RegWriteE = 1; ex_if.RdE = 5'(i + 1);
      ex_if.ALUControlE = vt[i].op; ex_if.ALUSrcE = vt[i].alusrc;
      ex_if.BranchE = vt[i].branch; ex_if.JumpE = vt[i].jump; ex_if.JALRctrlE = vt[i].jalr;
      ex_if.ForwardAE = vt[i].fa; ex_if.ForwardBE = vt[i].fb;
      ex_if.RD1E = vt[i].rd1; ex_if.RD2E = vt[i].rd2; ex_if.ImmExtE = vt[i].imm;
      ex_if.ResultW = vt[i].resw; ex_if.PCE = vt[i].pce; ex_if.PCPlus4E = vt[i].pcp4;
      #1;
      chk($sformatf("vec%0d_PCSrcE", i), {31'd0, ex_if.PCSrcE}, {31'd0, vt[i].exp_pcsrc});
      chk($sformatf("vec%0d_PCTargetE", i), ex_if.PCTargetE, vt[i].exp_tgt);
      chk($sformatf("vec%0d_BusyE", i), {31'd0, ex_if.BusyE}, 0);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_ALUResultM", i), ex_if.ALUResultM, vt[i].exp_alu);
      chk($sformatf("vec%0d_PCPlus4M", i), ex_if.PCPlus4M, vt[i].pcp4);
      chk($sformatf("vec%0d_RdM", i), {27'd0, ex_if.RdM}, i + 1);
    end
    prev_alu = vt[9].exp_alu;

    // Randomized non-mul traffic against the reference model
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      ex_if.RegWriteE = 1'($urandom); ex_if.MemWriteE = 1'($urandom);
      ex_if.ResultSrcE = 2'($urandom); ex_if.ALUControlE = 3'($urandom_range(0, 6));
      ex_if.ALUSrcE = 1'($urandom); ex_if.BranchE = 1'($urandom);
      ex_if.JumpE = ($urandom_range(0, 3) == 0); ex_if.JALRctrlE = 1'($urandom);
      ex_if.ForwardAE = 2'($urandom); ex_if.ForwardBE = 2'($urandom);
      ex_if.RD1E = $urandom; ex_if.RD2E = ($urandom_range(0, 3) == 0) ? ex_if.RD1E : $urandom;
      ex_if.ImmExtE = $urandom; ex_if.ResultW = $urandom; ex_if.PCE = $urandom;
      ex_if.PCPlus4E = $urandom; ex_if.RdE = 5'($urandom);
      a   = ref_fwd(ex_if.ForwardAE, ex_if.RD1E, ex_if.ResultW, prev_alu);
      wd  = ref_fwd(ex_if.ForwardBE, ex_if.RD2E, ex_if.ResultW, prev_alu);
      b   = ex_if.ALUSrcE ? ex_if.ImmExtE : wd;
      res = ref_alu(a, b, ex_if.ALUControlE);
      pcsrc = ex_if.JumpE || (ex_if.BranchE && res != 0);
      #1;
      chk($sformatf("rnd%0d_PCSrcE", i), {31'd0, ex_if.PCSrcE}, {31'd0, pcsrc});
      chk($sformatf("rnd%0d_PCTargetE", i), ex_if.PCTargetE,
          ex_if.JALRctrlE ? (res & 32'hFFFFFFFE) : (ex_if.PCE + ex_if.ImmExtE));
      @(posedge clk); #1;
      chk($sformatf("rnd%0d_ALUResultM", i), ex_if.ALUResultM, res);
      chk($sformatf("rnd%0d_WriteDataM", i), ex_if.WriteDataM, wd);
      chk($sformatf("rnd%0d_ctrlM", i),
          {25'd0, ex_if.RegWriteM, ex_if.MemWriteM, ex_if.ResultSrcM, ex_if.RdM},
          {25'd0, ex_if.RegWriteE, ex_if.MemWriteE, ex_if.ResultSrcE, ex_if.RdE});
      prev_alu = res;
    end

    // A bubble carrying op 111 must not start the multiplier
    @(negedge clk);
    idle_inputs();
    ex_if.ALUControlE = 3'b111; ex_if.RD1E = 7; ex_if.RD2E = 6;
    #1;
    chk("mul_bubble_busy", {31'd0, ex_if.BusyE}, 0);
    @(posedge clk); #1;
    chk("mul_bubble_busy_after", {31'd0, ex_if.BusyE}, 0);

    // Multiplies, including back-to-back
    do_mul("mul7x6", 32'd7, 32'd6);
    do_mul("mulFFx2", 32'hFFFFFFFF, 32'd2);
    do_mul("mul3x0", 32'd3, 32'd0);
    a = $urandom; b = $urandom;
    do_mul("mulrnd", a, b);

    // Reset during the 10th MUL cycle
    @(negedge clk);
    idle_inputs();
    ex_if.RegWriteE = 1; ex_if.ALUControlE = 3'b111; ex_if.RD1E = 7; ex_if.RD2E = 6;
    ex_if.RdE = 5'd9;
    repeat (10) @(posedge clk);
    #2;
    chk("rst_pre_busy", {31'd0, ex_if.BusyE}, 1);
    rst = 1;
    #1;
    chk("rst_busy", {31'd0, ex_if.BusyE}, 0);
    chk_m_zero("rst_mid_mul");
    @(negedge clk);
    rst = 0;
    idle_inputs();
    ex_if.RegWriteE = 1; ex_if.RD1E = 2; ex_if.RD2E = 3; ex_if.RdE = 5'd4;
    #1;
    chk("post_rst_busy", {31'd0, ex_if.BusyE}, 0);
    @(posedge clk); #1;
    chk("post_rst_add", ex_if.ALUResultM, 5);
    chk("post_rst_RegWriteM", {31'd0, ex_if.RegWriteM}, 1);
    chk("post_rst_RdM", {27'd0, ex_if.RdM}, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
